// File: rtl/tft_spi_pkg.sv
// Shared definitions for the TFT SPI receive path.
// Holds the default word width, synchronizer depth and idle timeout, plus the
// receive FSM state encoding used by tft_spi_rx.
package tft_spi_pkg;

  localparam int unsigned DefaultWidth      = 16;
  localparam int unsigned DefaultSyncStages = 2;
  localparam int unsigned DefaultIdleCycles = 64;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } rx_state_e;

endpackage

// File: rtl/tft_spi_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk_i  - sampling clock
//   rst_i  - synchronous active-high reset
//   d_i    - asynchronous input level
//   rise_o - one-cycle pulse per rising edge of d_i (registered)
// SYNC_STAGES must be at least 2.
module tft_spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
    // Registered pulse: one cycle after the last stage goes high.
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/tft_spi_rx.sv
// SPI mode-0 slave receiver for the TFT link, MSB first.
// Ports:
//   sys_clk_i    - system clock
//   sys_rst_i    - synchronous active-high reset
//   SPI_CLK      - serial clock from the master, asynchronous to sys_clk_i
//   SPI_MOSI     - serial data, sampled on SPI_CLK rising edge
//   data_o       - last received word
//   valid_o      - data_o holds an unread word
//   ready_i      - consumer accepts data_o when valid_o && ready_i
//   overrun_o    - one-cycle pulse: a completed word was dropped
//   frame_err_o  - one-cycle pulse: partial word aborted by idle timeout
//   word_count_o - number of words loaded into data_o (wraps)
module tft_spi_rx
  import tft_spi_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned IDLE_CYCLES = DefaultIdleCycles
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             SPI_CLK,
  input  logic             SPI_MOSI,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  output logic             frame_err_o,
  output logic [15:0]      word_count_o
);

  localparam int unsigned BitCntW  = $clog2(WIDTH + 1);
  localparam int unsigned IdleCntW = $clog2(IDLE_CYCLES + 1);
  localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(WIDTH - 1);
  localparam logic [IdleCntW-1:0] IdleLast = IdleCntW'(IDLE_CYCLES - 1);

  logic                   spi_rise;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_bit;

  rx_state_e              state_q, state_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IdleCntW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic [15:0]            word_cnt_q, word_cnt_d;

  logic [WIDTH-1:0]       shift_next;
  logic                   word_done;
  logic                   timeout;

  tft_spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clk_sync (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .d_i   (SPI_CLK),
    .rise_o(spi_rise)
  );

  assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    word_cnt_d  = word_cnt_q;
    word_done   = 1'b0;
    shift_next  = {shift_q[WIDTH-2:0], mosi_bit};
    timeout     = 1'b0;

    unique case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
      end
      StShift: begin
        idle_cnt_d = spi_rise ? '0 : idle_cnt_q + 1'b1;
        // Timeout takes priority over an edge arriving in the same cycle.
        timeout    = (idle_cnt_q == IdleLast);
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      shift_d     = '0;
      bit_cnt_d   = '0;
      idle_cnt_d  = '0;
      state_d     = StIdle;
    end else if (spi_rise) begin
      if (bit_cnt_q == LastBit) begin
        word_done  = 1'b1;
        shift_d    = '0;
        bit_cnt_d  = '0;
        idle_cnt_d = '0;
        state_d    = StIdle;
      end else begin
        shift_d   = shift_next;
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = StShift;
      end
    end

    if (word_done) begin
      if (!valid_q || ready_i) begin
        data_d     = shift_next;
        valid_d    = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      mosi_sync_q <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign overrun_o    = overrun_q;
  assign frame_err_o  = frame_err_q;
  assign word_count_o = word_cnt_q;

endmodule

// File: tb/tb_tft_spi_rx.sv
// Directed bench for tft_spi_rx: SPI master model, output monitor and a
// scoreboard of words expected to be loaded into data_o.
module tb_tft_spi_rx;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i = 1'b1;
  logic        SPI_CLK   = 1'b0;
  logic        SPI_MOSI  = 1'b0;
  logic        ready_i   = 1'b0;
  logic [15:0] data_o;
  logic        valid_o;
  logic        overrun_o;
  logic        frame_err_o;
  logic [15:0] word_count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  int          ovr_cnt = 0;
  int          fe_cnt  = 0;
  int          vld_cnt = 0;
  logic [15:0] wc_prev = 16'h0;

  int ovr0, fe0, vld0;

  always #5 sys_clk_i = ~sys_clk_i;

  tft_spi_rx dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .SPI_CLK     (SPI_CLK),
    .SPI_MOSI    (SPI_MOSI),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o),
    .word_count_o(word_count_o)
  );

  // Monitor: samples on the falling edge, records every load of data_o.
  always @(negedge sys_clk_i) begin
    if (!sys_rst_i) begin
      if (overrun_o === 1'b1) ovr_cnt++;
      if (frame_err_o === 1'b1) fe_cnt++;
      if (valid_o === 1'b1) vld_cnt++;
      if (word_count_o !== wc_prev) got_q.push_back(data_o);
    end
    wc_prev = word_count_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag);
    n_cmp++;
    assert (got_q.size() != 0 && exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s: observed %0d loaded words, expected %0d", tag, got_q.size(),
             exp_q.size());
    end
    if (got_q.size() != 0 && exp_q.size() != 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge sys_clk_i);
    sys_rst_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    @(negedge sys_clk_i);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic snap();
    ovr0 = ovr_cnt;
    fe0  = fe_cnt;
    vld0 = vld_cnt;
  endtask

  // Mode-0 master: MOSI changes while SPI_CLK is low, 4 sys cycles per phase.
  // ready_pulse raises ready_i for exactly the cycle the last bit completes.
  task automatic send_word(input logic [15:0] w, input int nbits, input bit ready_pulse);
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = w[15-i];
      repeat (4) @(negedge sys_clk_i);
      SPI_CLK = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge sys_clk_i);
        if (ready_pulse && i == nbits - 1 && k == 2) ready_i = 1'b1;
        if (ready_pulse && i == nbits - 1 && k == 3) ready_i = 1'b0;
      end
      SPI_CLK = 1'b0;
    end
    repeat (4) @(negedge sys_clk_i);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    @(negedge sys_clk_i);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_frame_err", frame_err_o, 0);
    chk("rst_word_count", word_count_o, 0);

    // Single word, consumer always ready
    snap();
    ready_i = 1'b1;
    exp_q.push_back(16'hA55A);
    send_word(16'hA55A, 16, 1'b0);
    chk_sb("a55a_data");
    chk("a55a_valid_cycles", vld_cnt - vld0, 1);
    chk("a55a_word_count", word_count_o, 1);
    chk("a55a_valid_now", valid_o, 0);

    // Overrun: second word dropped while first is unread
    do_reset();
    snap();
    ready_i = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 16, 1'b0);
    send_word(16'hBEEF, 16, 1'b0);
    chk_sb("ovr_data_loaded");
    chk("ovr_data_o", data_o, 16'h1234);
    chk("ovr_valid_held", valid_o, 1);
    chk("ovr_pulses", ovr_cnt - ovr0, 1);
    chk("ovr_word_count", word_count_o, 1);
    chk("ovr_no_extra_load", got_q.size(), 0);

    // Accept without completion clears valid_o, data_o held
    ready_i = 1'b1;
    @(negedge sys_clk_i);
    ready_i = 1'b0;
    chk("accept_valid_clr", valid_o, 0);
    chk("accept_data_hold", data_o, 16'h1234);

    // Accept in the completion cycle of the second word
    do_reset();
    snap();
    exp_q.push_back(16'h1111);
    send_word(16'h1111, 16, 1'b0);
    exp_q.push_back(16'h2222);
    send_word(16'h2222, 16, 1'b1);
    chk_sb("same_cycle_first");
    chk_sb("same_cycle_second");
    chk("same_cycle_data", data_o, 16'h2222);
    chk("same_cycle_valid", valid_o, 1);
    chk("same_cycle_overrun", ovr_cnt - ovr0, 0);
    chk("same_cycle_word_count", word_count_o, 2);

    // Idle timeout aborts a 7-bit fragment, next word still received
    do_reset();
    snap();
    ready_i = 1'b1;
    send_word(16'hA5A5, 7, 1'b0);
    repeat (100) @(negedge sys_clk_i);
    chk("timeout_pulses", fe_cnt - fe0, 1);
    chk("timeout_no_load", word_count_o, 0);
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF, 16, 1'b0);
    chk_sb("after_timeout_data");
    chk("after_timeout_word_count", word_count_o, 1);
    chk("after_timeout_no_new_err", fe_cnt - fe0, 1);

    // Reset mid-word discards the fragment without a frame error
    do_reset();
    send_word(16'hFFFF, 9, 1'b0);
    do_reset();
    snap();
    exp_q.push_back(16'h8001);
    send_word(16'h8001, 16, 1'b0);
    repeat (80) @(negedge sys_clk_i);
    chk_sb("rst_mid_data");
    chk("rst_mid_frame_err", fe_cnt - fe0, 0);
    chk("rst_mid_word_count", word_count_o, 1);

    // Word counter wraps from 0xFFFF to 0x0000
    @(posedge sys_clk_i);
    #1;
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge sys_clk_i);
    release dut.word_cnt_q;
    repeat (2) @(negedge sys_clk_i);
    got_q.delete();
    exp_q.push_back(16'h0F0F);
    send_word(16'h0F0F, 16, 1'b0);
    chk_sb("wrap_data");
    chk("wrap_word_count", word_count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tft_spi_rx.md
TFT_SPI_RX -- requirements
Module: tft_spi_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: bits per SPI word.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on SPI inputs, minimum 2.
REQ-003 The block SHALL have parameter IDLE_CYCLES, default 64: sys_clk_i cycles without an SPI_CLK rising edge that abort a partial word.
REQ-004 The block SHALL run on one clock, sys_clk_i; reset is sys_rst_i, synchronous and active-high.
REQ-005 The block SHALL have port sys_clk_i  input  1  system clock.
REQ-006 The block SHALL have port sys_rst_i  input  1  synchronous active-high reset.
REQ-007 The block SHALL have port SPI_CLK  input  1  serial clock from TFT_SPI master, asynchronous to sys_clk_i.
REQ-008 The block SHALL have port SPI_MOSI  input  1  serial data, MSB first, valid on SPI_CLK rising edge (mode 0).
REQ-009 The block SHALL have port data_o  output  WIDTH  last received word.
REQ-010 The block SHALL have port valid_o  output  1  data_o holds an unread word.
REQ-011 The block SHALL have port ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
REQ-012 The block SHALL have port overrun_o  output  1  one-cycle pulse: completed word dropped.
REQ-013 The block SHALL have port frame_err_o  output  1  one-cycle pulse: partial word aborted by idle timeout.
REQ-014 The block SHALL have port word_count_o  output  16  count of words loaded into data_o, wraps 0xFFFF->0x0000.

Function
REQ-015 SPI_CLK and SPI_MOSI SHALL each pass through SYNC_STAGES flops; rising edge = synced high && previous synced low, one sys_clk_i pulse.
REQ-016 MOSI SHALL be sampled from the synchronized MOSI in the same cycle as the edge pulse; input constraint: each SPI_CLK high/low phase >= 2 sys_clk_i periods.
REQ-017 The FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on first edge pulse (bit shifted, bit_cnt=1).
REQ-018 In SHIFT each edge pulse SHALL shift MOSI into the LSB and increment bit_cnt; on the WIDTH-th bit the word completes and the FSM returns to IDLE.
REQ-019 Latency: valid_o SHALL rise SYNC_STAGES+1 sys_clk_i edges after the edge at which synchronizer stage 1 first captures the WIDTH-th SPI_CLK high.
REQ-020 On completion with valid_o=0, or valid_o=1 and ready_i=1 same cycle: data_o loads the new word, valid_o=1, word_count_o increments.
REQ-021 On completion with valid_o=1 and ready_i=0: new word discarded, data_o unchanged, overrun_o pulses 1 cycle, word_count_o unchanged.
REQ-022 valid_o && ready_i without completion SHALL clear valid_o next cycle; data_o holds its value.
REQ-023 An idle counter SHALL run in SHIFT, clear on every edge pulse; at IDLE_CYCLES: frame_err_o pulses, shift register and bit_cnt clear, FSM to IDLE.
REQ-024 Idle counter SHALL not run in IDLE; no timeout in IDLE.
REQ-025 Edge pulse in the same cycle the timeout reaches IDLE_CYCLES: timeout wins, bit discarded.

Reset
REQ-026 sys_rst_i SHALL clear: synchronizers, FSM to IDLE, bit_cnt, idle counter, shift register, data_o=0, valid_o=0, overrun_o=0, frame_err_o=0, word_count_o=0.
REQ-027 Reset mid-word SHALL discard the partial word with no frame_err_o pulse; first edge after reset release starts a new word.

Structure
REQ-028 Package tft_spi_pkg SHALL hold WIDTH default 16, FSM state encoding (IDLE, SHIFT), and IDLE_CYCLES default.
REQ-029 Synchronizer plus rising-edge detector SHALL be sub-module tft_spi_sync_edge (parameter SYNC_STAGES), instantiated once for SPI_CLK; MOSI uses a plain synchronizer of equal depth.

Verification
REQ-030 Drive 16'hA55A via TFT_SPI master, ready_i=1 -> data_o=16'hA55A, valid_o high 1 cycle, word_count_o=1.
REQ-031 16'h1234 then 16'hBEEF, ready_i=0 -> data_o=16'h1234, valid_o held, one overrun_o pulse, word_count_o=1.
REQ-032 Send 7 bits, then SPI_CLK static 64 cycles -> one frame_err_o pulse; next 16'h00FF received correctly.
REQ-033 ready_i=1 asserted in the completion cycle of a second word -> first accepted, data_o=second word, valid_o stays 1, no overrun_o.
REQ-034 Assert sys_rst_i after 9 bits of 16'hFFFF, then send 16'h8001 -> data_o=16'h8001, no frame_err_o.
REQ-035 Preload word_count_o to 0xFFFF via 65535 words -> next word gives word_count_o=0x0000.
